serial_byte_rx: RTL and testbench

Upstream feeder for the 8-bit enable-gated parity register stage. Deserializes a UART-style serial line (idle high, 1 start bit, LSB-first data, 1 stop bit) into parallel bytes. Presents each good byte on data with a one-cycle en strobe, which is wired directly to the downstream register's data/en inputs. Flags framing errors and, optionally, parity errors.

---
 rtl/serial_byte_rx_if.sv | 22 ++
 rtl/serial_byte_rx.sv | 143 ++++++++++++++
 tb/tb_serial_byte_rx.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_byte_rx_if.sv
// serial_byte_rx_if: serial line in, strobed byte and status out.
// slave = receiver side, master = line driver / byte consumer side.
interface serial_byte_rx_if #(
   parameter int DATA_W = 8
);
   logic              sin;
   logic [DATA_W-1:0] data;
   logic              en;
   logic              busy;
   logic              frame_err;
   logic              parity_err;

   modport slave (
      input  sin,
      output data, en, busy, frame_err, parity_err
   );

   modport master (
      output sin,
      input  data, en, busy, frame_err, parity_err
   );
endinterface

// File: rtl/serial_byte_rx.sv
// serial_byte_rx: UART-style deserializer feeding a byte register stage.
// Define PARITY_CHECK_EN to add an even-parity bit after the data bits.
module serial_byte_rx #(
   parameter int CLKS_PER_BIT = 4,
   parameter int DATA_W       = 8
) (
   input logic             clk,
   input logic             reset,
   serial_byte_rx_if.slave bus
);
   localparam int H  = CLKS_PER_BIT / 2;
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] HALF_END = CW'(H - 1);
   localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP
   } state_t;

`ifdef PARITY_CHECK_EN
   localparam state_t AFTER_DATA = PARITY;
`else
   localparam state_t AFTER_DATA = STOP;
`endif

   state_t            state, nxt;
   logic              sync1, sin_s;
   logic [CW-1:0]     cnt;
   logic [BW-1:0]     bit_idx;
   logic [DATA_W-1:0] shift;
   logic              armed;
   logic              sample;
   logic              en_d, ferr_d;
   logic [DATA_W-1:0] data_q;
   logic              en_q, ferr_q;

   // two-flop synchronizer, idles high
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b1;
         sin_s <= 1'b1;
      end else begin
         sync1 <= bus.sin;
         sin_s <= sync1;
      end
   end

   // mid-bit sample point for the current state
   always_comb begin
      sample = 1'b0;
      unique case (state)
         START:              sample = (cnt == HALF_END);
         DATA, PARITY, STOP: sample = (cnt == BIT_END);
         default:            sample = 1'b0;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= nxt;
   end

   // next-state logic; armed blocks re-triggering on a stuck-low line
   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:   if (!sin_s && armed) nxt = START;
         START:  if (sample) nxt = sin_s ? IDLE : DATA;
         DATA:   if (sample && bit_idx == LAST_BIT) nxt = AFTER_DATA;
         PARITY: if (sample) nxt = STOP;
         STOP:   if (sample) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // output decode: pulses are decided at the stop sample
   always_comb begin
      en_d   = (state == STOP) && sample && sin_s;
      ferr_d = (state == STOP) && sample && !sin_s;
   end

   // counters, shift register and re-arm flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
         armed   <= 1'b0;
      end else begin
         cnt <= (state == IDLE || sample) ? '0 : cnt + CW'(1);
         if (state != DATA)
            bit_idx <= '0;
         else if (sample)
            bit_idx <= bit_idx + BW'(1);
         if (state == DATA && sample)
            shift <= {sin_s, shift[DATA_W-1:1]};
         if (sin_s)
            armed <= 1'b1;
         else if (ferr_d)
            armed <= 1'b0;
      end
   end

   // registered outputs; data only moves on a good frame
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_q <= '0;
         en_q   <= 1'b0;
         ferr_q <= 1'b0;
      end else begin
         en_q   <= en_d;
         ferr_q <= ferr_d;
         if (en_d) data_q <= shift;
      end
   end

`ifdef PARITY_CHECK_EN
   logic par_bit, perr_q;

   // capture parity bit and flag mismatch alongside en
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         par_bit <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         if (state == PARITY && sample) par_bit <= sin_s;
         perr_q <= en_d && ((^shift) ^ par_bit);
      end
   end

   assign bus.parity_err = perr_q;
`else
   assign bus.parity_err = 1'b0;
`endif

   assign bus.data      = data_q;
   assign bus.en        = en_q;
   assign bus.frame_err = ferr_q;
   assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_serial_byte_rx.sv
// tb_serial_byte_rx: scoreboard bench for the serial byte receiver.
// Frames are driven on negedges; a monitor logs DUT pulses for the tasks.
module tb_serial_byte_rx;
   localparam int CPB = 4;

   typedef struct packed {
      logic [7:0] d;
      logic       p;
      logic       b;
   } obs_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   en_cnt = 0;
   int   ferr_cnt = 0;
   int   perr_cnt = 0;
   int   both_cnt = 0;
   obs_t       obs_q[$];
   logic [7:0] exp_q[$];
   logic       exp_p_q[$];
   logic [7:0] last_good = 8'h00;

   serial_byte_rx_if #(.DATA_W(8)) bus();

   serial_byte_rx #(
      .CLKS_PER_BIT(CPB),
      .DATA_W(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // log every output pulse seen out of reset
   always @(negedge clk) begin
      if (reset) begin
         if (bus.en) begin
            obs_q.push_back({bus.data, bus.parity_err, bus.busy});
            en_cnt++;
         end
         if (bus.frame_err) ferr_cnt++;
         if (bus.parity_err) perr_cnt++;
         if (bus.en && bus.frame_err) both_cnt++;
      end
   end

   task automatic bit_out(input logic v);
      bus.sin = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_ok);
      bit_out(1'b0);
      for (int i = 0; i < 8; i++) bit_out(b[i]);
`ifdef PARITY_CHECK_EN
      bit_out(^b);
`endif
      bit_out(stop_ok);
      bus.sin = 1'b1;
   endtask

   task automatic settle();
      bus.sin = 1'b1;
      repeat (3 * CPB) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.data, bus.en, bus.busy, bus.frame_err, bus.parity_err} !== 12'h0)
         $display("FAIL reset_outputs: got %h want 000",
                  {bus.data, bus.en, bus.busy, bus.frame_err, bus.parity_err});
      if ({bus.data, bus.en, bus.busy, bus.frame_err, bus.parity_err} !== 12'h0)
         errors++;
      reset = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_busy: got %b want 0", bus.busy);
      end
   endtask

   task automatic test_single();
      int   e0 = en_cnt;
      int   f0 = ferr_cnt;
      obs_t o;
      exp_q.push_back(8'h71);
      send_frame(8'h71, 1'b1);
      settle();
      checks++;
      if (en_cnt - e0 !== 1) begin
         errors++;
         $display("FAIL single_en_count: got %0d want 1", en_cnt - e0);
      end
      checks++;
      if (ferr_cnt - f0 !== 0) begin
         errors++;
         $display("FAIL single_ferr: got %0d want 0", ferr_cnt - f0);
      end
      while (exp_q.size() > 0) begin
         logic [7:0] x = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL single_data: got none want %h", x);
         end else begin
            o = obs_q.pop_front();
            if (o.d !== x) begin
               errors++;
               $display("FAIL single_data: got %h want %h", o.d, x);
            end
            checks++;
            if (o.b !== 1'b0) begin
               errors++;
               $display("FAIL single_busy_at_en: got %b want 0", o.b);
            end
         end
      end
      last_good = 8'h71;
   endtask

   task automatic test_back_to_back();
      int         e0 = en_cnt;
      int         f0 = ferr_cnt;
      logic [7:0] seq [3];
      obs_t       o;
      seq = '{8'h11, 8'h77, 8'hC1};
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(seq[i]);
         send_frame(seq[i], 1'b1);
      end
      settle();
      checks++;
      if (en_cnt - e0 !== 3) begin
         errors++;
         $display("FAIL b2b_en_count: got %0d want 3", en_cnt - e0);
      end
      checks++;
      if (ferr_cnt - f0 !== 0) begin
         errors++;
         $display("FAIL b2b_ferr: got %0d want 0", ferr_cnt - f0);
      end
      while (exp_q.size() > 0) begin
         logic [7:0] x = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL b2b_data: got none want %h", x);
         end else begin
            o = obs_q.pop_front();
            if (o.d !== x) begin
               errors++;
               $display("FAIL b2b_data: got %h want %h", o.d, x);
            end
         end
      end
      last_good = 8'hC1;
   endtask

   task automatic test_glitch();
      int e0 = en_cnt;
      int f0 = ferr_cnt;
      bus.sin = 1'b0;
      @(negedge clk);
      bus.sin = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL glitch_busy_rise: got %b want 1", bus.busy);
      end
      settle();
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL glitch_busy_fall: got %b want 0", bus.busy);
      end
      checks++;
      if ((en_cnt - e0) + (ferr_cnt - f0) !== 0) begin
         errors++;
         $display("FAIL glitch_pulses: got %0d want 0",
                  (en_cnt - e0) + (ferr_cnt - f0));
      end
   endtask

   task automatic test_frame_err();
      int e0 = en_cnt;
      int f0 = ferr_cnt;
      send_frame(8'hA5, 1'b0);
      settle();
      checks++;
      if (ferr_cnt - f0 !== 1) begin
         errors++;
         $display("FAIL ferr_count: got %0d want 1", ferr_cnt - f0);
      end
      checks++;
      if (en_cnt - e0 !== 0) begin
         errors++;
         $display("FAIL ferr_en: got %0d want 0", en_cnt - e0);
      end
      checks++;
      if (bus.data !== last_good) begin
         errors++;
         $display("FAIL ferr_data_held: got %h want %h", bus.data, last_good);
      end
   endtask

   task automatic test_stuck_low();
      int   e0 = en_cnt;
      int   f0 = ferr_cnt;
      obs_t o;
      bus.sin = 1'b0;
      repeat (30 * CPB) @(negedge clk);
      checks++;
      if (ferr_cnt - f0 !== 1) begin
         errors++;
         $display("FAIL stuck_ferr: got %0d want 1", ferr_cnt - f0);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL stuck_busy: got %b want 0", bus.busy);
      end
      settle();
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1);
      settle();
      checks++;
      if (en_cnt - e0 !== 1) begin
         errors++;
         $display("FAIL stuck_recover_en: got %0d want 1", en_cnt - e0);
      end
      while (exp_q.size() > 0) begin
         logic [7:0] x = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL stuck_recover_data: got none want %h", x);
         end else begin
            o = obs_q.pop_front();
            if (o.d !== x) begin
               errors++;
               $display("FAIL stuck_recover_data: got %h want %h", o.d, x);
            end
         end
      end
      last_good = 8'h5A;
   endtask

   task automatic test_reset_mid();
      int         e0 = en_cnt;
      int         f0 = ferr_cnt;
      logic [7:0] b  = 8'h3C;
      obs_t       o;
      bit_out(1'b0);
      for (int i = 0; i < 4; i++) bit_out(b[i]);
      bus.sin = b[4];
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if ({bus.data, bus.en, bus.busy, bus.frame_err, bus.parity_err} !== 12'h0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got %h want 000",
                  {bus.data, bus.en, bus.busy, bus.frame_err, bus.parity_err});
      end
      bus.sin = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      settle();
      settle();
      checks++;
      if ((en_cnt - e0) + (ferr_cnt - f0) !== 0) begin
         errors++;
         $display("FAIL mid_reset_pulses: got %0d want 0",
                  (en_cnt - e0) + (ferr_cnt - f0));
      end
      checks++;
      if (bus.data !== 8'h00) begin
         errors++;
         $display("FAIL mid_reset_data: got %h want 00", bus.data);
      end
      exp_q.push_back(8'h0F);
      send_frame(8'h0F, 1'b1);
      settle();
      checks++;
      if (en_cnt - e0 !== 1) begin
         errors++;
         $display("FAIL post_reset_en: got %0d want 1", en_cnt - e0);
      end
      while (exp_q.size() > 0) begin
         logic [7:0] x = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL post_reset_data: got none want %h", x);
         end else begin
            o = obs_q.pop_front();
            if (o.d !== x) begin
               errors++;
               $display("FAIL post_reset_data: got %h want %h", o.d, x);
            end
         end
      end
      last_good = 8'h0F;
   endtask

`ifdef PARITY_CHECK_EN
   task automatic test_parity();
      logic [7:0] b = 8'h71;
      obs_t       o;
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back(b);
         exp_p_q.push_back(k[0]);
         bit_out(1'b0);
         for (int i = 0; i < 8; i++) bit_out(b[i]);
         bit_out((^b) ^ k[0]);
         bit_out(1'b1);
         settle();
      end
      while (exp_q.size() > 0) begin
         logic [7:0] x  = exp_q.pop_front();
         logic       xp = exp_p_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL parity_frame: got none want %h", x);
         end else begin
            o = obs_q.pop_front();
            if (o.d !== x) begin
               errors++;
               $display("FAIL parity_data: got %h want %h", o.d, x);
            end
            checks++;
            if (o.p !== xp) begin
               errors++;
               $display("FAIL parity_err: got %b want %b", o.p, xp);
            end
         end
      end
      checks++;
      if (perr_cnt !== 1) begin
         errors++;
         $display("FAIL parity_count: got %0d want 1", perr_cnt);
      end
   endtask
`endif

   task automatic test_pulses();
      checks++;
      if (both_cnt !== 0) begin
         errors++;
         $display("FAIL en_ferr_overlap: got %0d want 0", both_cnt);
      end
`ifndef PARITY_CHECK_EN
      checks++;
      if (perr_cnt !== 0) begin
         errors++;
         $display("FAIL parity_tied: got %0d want 0", perr_cnt);
      end
`endif
      checks++;
      if (obs_q.size() !== 0) begin
         errors++;
         $display("FAIL extra_bytes: got %0d want 0", obs_q.size());
      end
   endtask

   initial begin
      bus.sin = 1'b1;
      @(negedge clk);
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_stuck_low();
      test_reset_mid();
`ifdef PARITY_CHECK_EN
      test_parity();
`endif
      test_pulses();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
